// File: rtl/ace_rd_responder.sv
// Read-side ACE responder: one AR burst at a time, beats fetched from a
// synchronous-read block memory, R returned in order, then waits for rack.
module ace_rd_responder #(
  parameter int unsigned MEM_BASE   = 0,
  parameter int unsigned MEM_SIZE   = 65536,
  parameter int unsigned LATENCY    = 0,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned BLOCK_SIZE = 512,
  localparam int unsigned OFFSET_W  = $clog2(BLOCK_SIZE/8),
  localparam int unsigned MEM_AW    = $clog2(MEM_SIZE*8/BLOCK_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [ID_W-1:0]       arid,
  input  logic [7:0]            arlen,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [BLOCK_SIZE-1:0] rdata,
  output logic [3:0]            rresp,
  output logic [ID_W-1:0]       rid,
  output logic                  rlast,
  input  logic                  rack,
  output logic                  awready,
  output logic                  wready,
  output logic                  bvalid,
  output logic                  acvalid,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [BLOCK_SIZE-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ACK} state_e;

  localparam int unsigned CW = (LATENCY > 0) ? $clog2(LATENCY+1) : 1;
  localparam logic [CW-1:0] LAT = CW'(LATENCY);
  localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(MEM_BASE);
  localparam logic [ADDR_W:0] HI = LO + (ADDR_W+1)'(MEM_SIZE);
  localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(BLOCK_SIZE/8);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [1:0]            burst_q, burst_d;
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;
  logic                  arready_q, arready_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;

  logic [ADDR_W:0]       addr_x, addr_nx;
  logic [ADDR_W-1:0]     off;
  logic                  in_rng, beat_err, last;
  logic                  unused_off;

  // A carry out of the address adder marks the rest of the burst as wrapped.
  assign addr_x   = {1'b0, addr_q};
  assign in_rng   = (addr_x >= LO) && (addr_x < HI) && !wrap_q;
  assign beat_err = !in_rng || burst_q[1];
  assign last     = (beat_q == len_q);
  assign addr_nx  = addr_x + ((burst_q == 2'd1) ? STEP : '0);
  assign off      = addr_q - LO[ADDR_W-1:0];
  assign unused_off = ^off;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    wrap_d  = wrap_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (arvalid && arready_q) begin
          addr_d  = araddr;
          id_d    = arid;
          len_d   = arlen;
          burst_d = arburst;
          beat_d  = '0;
          wrap_d  = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        err_d   = beat_err;
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == LAT) rdata_d = err_q ? '0 : mem_rdata;
        if (cnt_q == '0) state_d = RESP;
        else cnt_d = cnt_q - CW'(1);
      end
      RESP: begin
        if (rready) begin
          if (!last) begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_nx[ADDR_W-1:0];
            wrap_d  = wrap_q | addr_nx[ADDR_W];
            state_d = ISSUE;
          end else begin
            state_d = rack ? IDLE : ACK;
          end
        end
      end
      ACK: begin
        if (rack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      arready_q <= arready_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign arready  = arready_q;
  assign rvalid   = (state_q == RESP);
  assign rdata    = rdata_q;
  assign rresp    = {2'b00, rvalid && err_q, 1'b0};
  assign rid      = id_q;
  assign rlast    = rvalid && last;
  assign mem_en   = (state_q == ISSUE) && !beat_err;
  assign mem_addr = off[OFFSET_W +: MEM_AW];

  assign awready  = 1'b0;
  assign wready   = 1'b0;
  assign bvalid   = 1'b0;
  assign acvalid  = 1'b0;

endmodule

// File: tb/tb_ace_rd_responder.sv
// Bench for ace_rd_responder: directed cases plus random bursts checked
// every cycle against a transaction-level model of the responder.
module tb_ace_rd_responder;

  localparam longint BASE = 'h1000;
  localparam longint SIZE = 4096;
  localparam int     LAT  = 2;
  localparam int     NBLK = 64;

  typedef struct {
    logic [511:0] d;
    logic [3:0]   resp;
    logic [3:0]   id;
    logic         last;
    logic         err;
    int           idx;
  } beat_t;

  logic         clk, rst;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [1:0]   arburst;
  logic         rvalid, rready, rlast, rack;
  logic [511:0] rdata;
  logic [3:0]   rresp, rid;
  logic         awready, wready, bvalid, acvalid;
  logic         mem_en;
  logic [5:0]   mem_addr;
  logic [511:0] mem_rdata;

  logic [511:0] mem [NBLK];
  beat_t        q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, exp_rv = -1;
  int n_beats = 0, n_memen = 0;
  int rr_pct = 100, ack_pct = 100;
  bit rack_man = 0;
  bit m_busy = 0, m_await = 0, ar_exp = 0;

  ace_rd_responder #(
    .MEM_BASE(32'h1000), .MEM_SIZE(4096), .LATENCY(LAT),
    .ADDR_W(32), .ID_W(4), .BLOCK_SIZE(512)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rid(rid), .rlast(rlast), .rack(rack),
    .awready(awready), .wready(wready), .bvalid(bvalid),
    .acvalid(acvalid), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Expected beats of one burst, straight from the address/range rules.
  function automatic void build(input logic [31:0] a, input logic [3:0] id,
                                input logic [7:0] len, input logic [1:0] bt);
    for (int b = 0; b <= int'(len); b++) begin
      longint ad;
      beat_t  e;
      ad = longint'(a) + ((bt == 2'd1) ? longint'(b) * 64 : 0);
      e.err  = (bt > 2'd1) || (ad < BASE) || (ad >= BASE + SIZE);
      e.idx  = e.err ? 0 : int'((ad - BASE) / 64);
      e.d    = e.err ? '0 : mem[e.idx];
      e.resp = e.err ? 4'b0010 : 4'b0000;
      e.id   = id;
      e.last = (b == int'(len));
      q.push_back(e);
    end
  endfunction

  initial begin
    @(posedge clk);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    rready = 1;
    rack = 0;
    forever begin
      @(posedge clk);
      #1;
      rready = rr_pct > int'($urandom_range(99));
      rack = rack_man || (ack_pct > int'($urandom_range(99)));
    end
  end

  // Compare process: every cycle the DUT outputs are checked against the model.
  initial begin
    bit rv_exp, me_exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rfields", {rdata, rresp, rid, rlast}, '0);
        q.delete();
        exp_rv = -1;
        m_busy = 0;
        m_await = 0;
        ar_exp = 0;
      end else begin
        cyc++;
        chk("tieoff", {awready, wready, bvalid, acvalid}, 0);
        chk("arready", arready, ar_exp);
        rv_exp = (exp_rv >= 0) && (cyc >= exp_rv);
        me_exp = (exp_rv >= 0) && (cyc == exp_rv - 2 - LAT) &&
                 (q.size() > 0) && !q[0].err;
        chk("rvalid", rvalid, rv_exp);
        chk("mem_en", mem_en, me_exp);
        if (mem_en) n_memen++;
        if (mem_en && me_exp) chk("mem_addr", mem_addr, q[0].idx);
        if (rvalid && q.size() > 0) begin
          chk("rdata", rdata, q[0].d);
          chk("rresp", rresp, q[0].resp);
          chk("rid", rid, q[0].id);
          chk("rlast", rlast, q[0].last);
        end
        if (arvalid && arready) begin
          build(araddr, arid, arlen, arburst);
          exp_rv = cyc + 3 + LAT;
          m_busy = 1;
        end
        if (rvalid && rready && q.size() > 0) begin
          n_beats++;
          if (!q[0].last) exp_rv = cyc + 3 + LAT;
          else begin
            exp_rv = -1;
            m_await = 1;
          end
          void'(q.pop_front());
        end
        if (m_await && rack) begin
          m_await = 0;
          m_busy = 0;
        end
        ar_exp = !m_busy;
      end
    end
  end

  task automatic ar(input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len, input logic [1:0] bt);
    bit ok = 0;
    @(posedge clk);
    #1;
    arvalid = 1;
    araddr = a;
    arid = id;
    arlen = len;
    arburst = bt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    arvalid = 0;
    chk("ar_accept", ok, 1);
  endtask

  task automatic wait_rv(output int k);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rvalid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #1;
      if (!m_busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_reached", ok, 1);
  endtask

  initial begin
    int k, b0, m0;
    bit ok;
    logic [31:0] a;
    int sel;
    rst = 0;
    arvalid = 0;
    araddr = '0;
    arid = '0;
    arlen = '0;
    arburst = '0;
    for (int i = 0; i < NBLK; i++)
      for (int w = 0; w < 16; w++) mem[i][w*32 +: 32] = $urandom;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // single beat, FIXED, id 3
    ar(32'h1040, 4'd3, 8'd0, 2'd0);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 6'd1);
    wait_rv(k);
    chk("t1_latency", k, 5);
    chk("t1_rdata", rdata, mem[1]);
    chk("t1_rid", rid, 4'd3);
    chk("t1_rresp", rresp, 4'd0);
    chk("t1_rlast", rlast, 1);
    wait_idle();

    // backpressure
    rr_pct = 0;
    b0 = n_beats;
    ar(32'h1080, 4'd5, 8'd0, 2'd1);
    wait_rv(k);
    chk("t2_latency", k, 5);
    repeat (5) begin
      @(negedge clk);
      chk("t2_stall_rvalid", rvalid, 1);
    end
    rr_pct = 100;
    wait_idle();
    chk("t2_beats", n_beats - b0, 1);

    // INCR burst of 4 from block 4
    b0 = n_beats;
    m0 = n_memen;
    ar(32'h1100, 4'd7, 8'd3, 2'd1);
    wait_idle();
    chk("t3_beats", n_beats - b0, 4);
    chk("t3_mem_en", n_memen - m0, 4);

    // errors: past end, crossing end, WRAP
    m0 = n_memen;
    ar(32'h2000, 4'd1, 8'd0, 2'd1);
    wait_idle();
    chk("t4_no_mem_en", n_memen - m0, 0);
    m0 = n_memen;
    ar(32'h1FC0, 4'd2, 8'd1, 2'd1);
    wait_idle();
    chk("t4_cross_mem_en", n_memen - m0, 1);
    ar(32'h1000, 4'd3, 8'd2, 2'd2);
    wait_idle();

    // delayed rack with an early AR
    ack_pct = 0;
    ar(32'h10C0, 4'd6, 8'd0, 2'd1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (m_await) begin
        ok = 1;
        break;
      end
    end
    chk("t5_last_beat", ok, 1);
    @(posedge clk);
    #1;
    arvalid = 1;
    araddr = 32'h1100;
    arid = 4'd7;
    arlen = 8'd1;
    arburst = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold", arready, 0);
    end
    rack_man = 1;
    @(negedge clk);
    chk("t5_rack_cycle", arready, 0);
    rack_man = 0;
    ack_pct = 100;
    @(negedge clk);
    chk("t5_reopen", arready, 1);
    @(posedge clk);
    #1 arvalid = 0;
    wait_idle();

    // reset during beat 2 of 4
    b0 = n_beats;
    ar(32'h1200, 4'd4, 8'd3, 2'd1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (n_beats == b0 + 1) begin
        ok = 1;
        break;
      end
    end
    chk("t6_beat1", ok, 1);
    @(negedge clk);
    #1;
    chk("t6_issue", mem_en, 1);
    rst = 0;
    #1;
    chk("t6_async_mem_en", mem_en, 0);
    chk("t6_async_rvalid", rvalid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    ar(32'h1040, 4'd9, 8'd0, 2'd0);
    wait_idle();

    // random bursts
    for (int t = 0; t < 120; t++) begin
      sel = int'($urandom_range(9));
      if (sel < 6)
        a = 32'h1000 + 32'($urandom_range(63)) * 64 +
            (($urandom_range(3) == 0) ? 32'($urandom_range(63)) : 32'd0);
      else if (sel == 6) a = 32'h2000 - 32'($urandom_range(1, 3)) * 64;
      else if (sel == 7) a = 32'($urandom_range(32'hFFF));
      else if (sel == 8) a = 32'h2000 + 32'($urandom_range(1000));
      else a = 32'hFFFF_FFC0 - 32'($urandom_range(2)) * 64;
      sel = int'($urandom_range(9));
      rr_pct = int'($urandom_range(20, 100));
      ack_pct = int'($urandom_range(20, 100));
      ar(a, 4'($urandom_range(15)), 8'($urandom_range(7)),
         (sel < 5) ? 2'd1 : (sel < 8) ? 2'd0 : (sel == 8) ? 2'd2 : 2'd3);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ace_rd_responder.md
# ace_rd_responder

Read-side ACE responder that services cache-line read requests issued by an instruction-fetch or data-cache initiator. It accepts one AR transaction at a time and fetches each beat from an external synchronous-read memory port with a configurable extra latency. It returns R beats with echoed ID and correct `rlast`, then waits for the initiator's `rack` before accepting the next request. It sits below the L1 caches as the memory/interconnect end of `ace_if`. Write, snoop and coherency channels are tied off.

## Interface

**Parameters**
- `MEM_BASE`, default 0: byte address of the first memory block.
- `MEM_SIZE`, default 65536: memory size in bytes. Must be a multiple of the block size.
- `LATENCY`, default 0: extra wait cycles inserted between memory read data and `rvalid`, per beat.
- Derived: `BLOCK_SIZE = ace_if.ACE_XDATA_WIDTH` bits; `OFFSET_W = $clog2(BLOCK_SIZE/8)`; `MEM_AW = $clog2(MEM_SIZE*8/BLOCK_SIZE)`.

**Ports**
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset. Assertion takes effect immediately; release is used synchronously.
- `ace_sif`  `ace_if.s`  —: responder side of ACE. Uses AR and R channels plus `rack`.
- `mem_en`  out  1: memory read enable, one cycle per beat.
- `mem_addr`  out  `MEM_AW`: block index, equal to `(addr - MEM_BASE) >> OFFSET_W`.
- `mem_rdata`  in  `BLOCK_SIZE`: read data, valid the cycle after `mem_en`.

## Operation

**State machine:** `IDLE → ISSUE → WAIT → RESP → (ISSUE | ACK) → IDLE`.
- **IDLE:** `arready=1`. On `arvalid && arready`, capture `araddr`, `arid`, `arlen` and `arburst`, clear the beat counter, and go to ISSUE.
- **ISSUE:** compute the current beat address.
  - In range: pulse `mem_en` and drive `mem_addr`.
  - Out of range (`addr < MEM_BASE` or `addr >= MEM_BASE+MEM_SIZE`) or unsupported burst (`arburst` ∉ {FIXED=0, INCR=1}): no `mem_en`; mark the beat as error.
  - Go to WAIT and load the wait counter with `LATENCY`.
- **WAIT:**
  - In the first WAIT cycle, capture `mem_rdata` into `rdata_q`, or 0 for an error beat.
  - Decrement the counter. At 0, go to RESP with `rvalid=1`.
- **RESP:** hold `rvalid`, `rdata`, `rresp`, `rid` and `rlast` stable until `rready`. On the handshake:
  - If not the last beat: increment the beat counter and advance the address by `BLOCK_SIZE/8` for INCR (FIXED keeps the address). Go to ISSUE.
  - If the last beat: go to ACK. If `rack` is high in the same cycle, go straight to IDLE.
- **ACK:** hold `arready=0` until `rack=1`, then go to IDLE.

**Field rules**
- `rresp[1:0]` is OKAY (`2'b00`), or SLVERR (`2'b10`) for an error beat. `rresp[3:2] = 0` (never IsShared or PassDirty).
- `rid` = captured `arid`.
- `rlast = (beat == arlen)`.
- `arsize` is ignored; every beat returns a full block.
- Range is checked per beat, so an INCR burst that crosses the memory end switches to SLVERR mid-burst. Beat count is always `arlen+1`.

**Tie-offs:** `awready=0`, `wready=0`, `bvalid=0`, `acvalid=0`, and all other responder-driven signals 0.

## Timing

- **Reset values:** `arready=0`, `rvalid=0`, `rlast=0`, `rdata=0`, `rresp=0`, `rid=0`, `mem_en=0`, state IDLE. `arready` rises on the first clock edge after `rst` is released.
- **Latency:** AR handshake at edge N → `mem_en` high in cycle N+1 → `rvalid` high in cycle N+3+LATENCY.
  - The same ISSUE→RESP spacing of 2+LATENCY cycles applies after every non-last R handshake.
- **Outstanding transactions:** at most one. `arready` stays 0 from the AR handshake until the cycle after `rack` is seen.
- **Reset mid-transaction:** outputs return to their reset values immediately. The transaction is dropped and `rack` is not awaited.
- **Counter widths:**
  - Beat counter: 8 bits, matching `arlen`.
  - Address arithmetic: `ADDR` width, wrapping modulo 2^ADDR; wrap-around is treated as out of range.

## Test plan

1. **Single-beat fetch.** Block 512 bit, `LATENCY=0`. `araddr=MEM_BASE+0x40`, `arlen=0`, `arburst=0`, `arid=3`, `rready=1`, `rack` in the handshake cycle → `mem_addr=1` at N+1; `rvalid` at N+3 with `rdata=mem[1]`, `rresp=0`, `rid=3`, `rlast=1`; `arready=1` again on the next cycle.
2. **Backpressure.** `LATENCY=2`, `rready` held 0 for 5 cycles after `rvalid` → `rvalid` first at N+5; `rdata`, `rresp` and `rlast` remain stable through the stall; exactly one beat is delivered.
3. **INCR burst.** `arlen=3`, INCR, start index 4 → 4 beats carrying `mem[4..7]`; `rlast` only on beat 4; `mem_en` is pulsed exactly 4 times.
4. **Error responses.**
   - `araddr=MEM_BASE+MEM_SIZE` → `rresp=2'b10`, `rdata=0`, no `mem_en`.
   - INCR `arlen=1` starting at the last block → beat 1 is OKAY, beat 2 is SLVERR.
   - `arburst=2` (WRAP) → SLVERR on all beats.
5. **Delayed rack.** `rack` asserted 3 cycles after the last R handshake → `arready=0` during those 3 cycles and 1 on the cycle after `rack`; a new AR presented early is not accepted until then.
6. **Reset mid-burst.** `rst` driven low during beat 2 of 4 → `rvalid=0` and `mem_en=0` asynchronously. After release, `arready=1` on the first edge and a fresh single-beat read completes correctly.
